// File: rtl/moore_pkg.sv
// Shared definitions for the Moore sequencer link receiver: state codes,
// receiver FSM encoding and the sequencer transition table.
package moore_pkg;

    localparam logic [3:0] S0 = 4'h0;
    localparam logic [3:0] S1 = 4'h1;
    localparam logic [3:0] S2 = 4'h2;
    localparam logic [3:0] S3 = 4'h3;
    localparam logic [3:0] S4 = 4'h4;
    localparam logic [3:0] S5 = 4'h5;

    // Returned by next_code for codes outside the sequencer alphabet.
    localparam logic [3:0] S_BAD = 4'hF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic logic is_legal_code(input logic [3:0] code);
        return (code <= S5);
    endfunction

    function automatic logic [3:0] next_code(input logic [3:0] code, input logic b);
        logic [3:0] nxt;
        case (code)
            S0:      nxt = b ? S3 : S1;
            S1:      nxt = b ? S5 : S2;
            S2:      nxt = b ? S0 : S3;
            S3:      nxt = b ? S1 : S4;
            S4:      nxt = b ? S2 : S5;
            S5:      nxt = b ? S4 : S0;
            default: nxt = S_BAD;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/moore_transition_check.sv
// Classifies one (prev, code) pair: is the code in range, is the pair a
// legal sequencer step, and which input bit produced it.
module moore_transition_check
    import moore_pkg::*;
(
    input  logic [3:0] prev,
    input  logic [3:0] code,
    output logic       legal_code,
    output logic       legal_trans,
    output logic       bit_inferred
);

    logic [5:0] match0;
    logic [5:0] match1;

    // One comparator pair per possible previous code; at most one bit is set.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_match
            localparam logic [3:0] PREV_C = 4'(gi);
            assign match0[gi] = (prev == PREV_C) && (code == next_code(PREV_C, 1'b0));
            assign match1[gi] = (prev == PREV_C) && (code == next_code(PREV_C, 1'b1));
        end
    endgenerate

    assign legal_code   = is_legal_code(code);
    assign legal_trans  = legal_code && (|(match0 | match1));
    assign bit_inferred = |match1;

endmodule

// File: rtl/moore_sequence_decoder.sv
// Receive end of the 6-state Moore sequencer link: recovers input bits from
// consecutive state codes, acquires lock, packs words and counts violations.
module moore_sequence_decoder
    import moore_pkg::*;
#(
    parameter int LOCK_N = 3,
    parameter int WORD_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clock_div,
    input  logic              reset,
    input  logic [3:0]        code_in,
    input  logic              code_valid,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [WORD_W-1:0] bits_word,
    output logic              word_valid,
    output logic              sync_lock,
    output logic              err_illegal,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORD_W - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    rx_state_t          state_q;
    logic [3:0]         prev_q;
    logic [3:0]         run_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [WORD_W-1:0]  shift_q;
    logic [WORD_W-1:0]  word_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               bit_out_q;
    logic               bit_valid_q;
    logic               word_valid_q;
    logic               sync_lock_q;
    logic               err_illegal_q;

    logic               legal_code;
    logic               legal_trans;
    logic               bit_inferred;
    logic [3:0]         run_d;
    logic [WORD_W-1:0]  shift_d;
    logic [ERR_W-1:0]   err_cnt_d;

    moore_transition_check u_check (
        .prev         (prev_q),
        .code         (code_in),
        .legal_code   (legal_code),
        .legal_trans  (legal_trans),
        .bit_inferred (bit_inferred)
    );

    assign run_d     = run_q + 4'd1;
    assign shift_d   = {shift_q[WORD_W-2:0], bit_inferred};
    assign err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;

    always_ff @(posedge clock_div) begin
        if (reset) begin
            state_q       <= HUNT;
            prev_q        <= S0;
            run_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            word_q        <= '0;
            err_cnt_q     <= '0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            word_valid_q  <= 1'b0;
            sync_lock_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            bit_valid_q   <= 1'b0;
            word_valid_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            if (code_valid) begin
                case (state_q)
                    HUNT: begin
                        if (legal_code) begin
                            prev_q  <= code_in;
                            run_q   <= '0;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!legal_code) begin
                            run_q   <= '0;
                            state_q <= HUNT;
                        end else if (legal_trans) begin
                            prev_q <= code_in;
                            // The step that completes lock carries no bit.
                            if (run_d == LOCK_C) begin
                                run_q       <= '0;
                                bit_cnt_q   <= '0;
                                state_q     <= LOCKED;
                                sync_lock_q <= 1'b1;
                            end else begin
                                run_q <= run_d;
                            end
                        end else begin
                            prev_q <= code_in;
                            run_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!legal_code) begin
                            err_illegal_q <= 1'b1;
                            err_cnt_q     <= err_cnt_d;
                            run_q         <= '0;
                            bit_cnt_q     <= '0;
                            state_q       <= HUNT;
                            sync_lock_q   <= 1'b0;
                        end else if (legal_trans) begin
                            prev_q      <= code_in;
                            bit_out_q   <= bit_inferred;
                            bit_valid_q <= 1'b1;
                            shift_q     <= shift_d;
                            if (bit_cnt_q == LAST_C) begin
                                word_q       <= shift_d;
                                word_valid_q <= 1'b1;
                                bit_cnt_q    <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else begin
                            err_illegal_q <= 1'b1;
                            err_cnt_q     <= err_cnt_d;
                            prev_q        <= code_in;
                            run_q         <= '0;
                            bit_cnt_q     <= '0;
                            state_q       <= CHECK;
                            sync_lock_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= HUNT;
                        sync_lock_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign bits_word   = word_q;
    assign word_valid  = word_valid_q;
    assign sync_lock   = sync_lock_q;
    assign err_illegal = err_illegal_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_moore_sequence_decoder.sv
// Scoreboard bench for moore_sequence_decoder: directed code streams push
// expected output events; a negedge monitor pops and compares them.
module tb_moore_sequence_decoder;

    localparam int WORD_W = 8;
    localparam int ERR_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        code_in;
    logic              code_valid;
    logic              bit_out;
    logic              bit_valid;
    logic [WORD_W-1:0] bits_word;
    logic              word_valid;
    logic              sync_lock;
    logic              err_illegal;
    logic [ERR_W-1:0]  err_count;

    always #5 clk = ~clk;

    moore_sequence_decoder #(.LOCK_N(3), .WORD_W(WORD_W), .ERR_W(ERR_W)) dut (
        .clock_div   (clk),
        .reset       (reset),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bits_word   (bits_word),
        .word_valid  (word_valid),
        .sync_lock   (sync_lock),
        .err_illegal (err_illegal),
        .err_count   (err_count)
    );

    typedef struct {
        logic              bv;
        logic              bo;
        logic              wv;
        logic [WORD_W-1:0] word;
        logic              lock;
        logic              ei;
        logic [ERR_W-1:0]  ecnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    logic [ERR_W-1:0] exp_ecnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic bv, input logic bo, input logic wv,
                        input logic [WORD_W-1:0] word, input logic lock, input logic ei);
        exp_t e;
        e.bv = bv; e.bo = bo; e.wv = wv; e.word = word;
        e.lock = lock; e.ei = ei; e.ecnt = exp_ecnt;
        exp_q.push_back(e);
    endtask

    task automatic exp_bit(input logic b, input logic wv, input logic [WORD_W-1:0] word);
        push(1'b1, b, wv, word, 1'b1, 1'b0);
    endtask

    task automatic exp_lock();
        push(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic exp_err();
        if (exp_ecnt != '1) exp_ecnt = exp_ecnt + 1'b1;
        push(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [3:0] c);
        code_valid = 1'b1;
        code_in    = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        code_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_out"},     32'(bit_out), 32'd0);
        check({tag, "_bit_valid"},   32'(bit_valid), 32'd0);
        check({tag, "_bits_word"},   32'(bits_word), 32'd0);
        check({tag, "_word_valid"},  32'(word_valid), 32'd0);
        check({tag, "_sync_lock"},   32'(sync_lock), 32'd0);
        check({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
        check({tag, "_err_count"},   32'(err_count), 32'd0);
    endtask

    // Monitor: any pulse or lock edge is an output event and must match the head.
    initial begin : monitor
        logic last_lock;
        exp_t e;
        last_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && (bit_valid || err_illegal || word_valid || (sync_lock !== last_lock))) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: bv=%b bo=%b wv=%b lock=%b ei=%b expected no event at %0t",
                             bit_valid, bit_out, word_valid, sync_lock, err_illegal, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_valid", 32'(bit_valid), 32'(e.bv));
                    if (e.bv) check("bit_out", 32'(bit_out), 32'(e.bo));
                    check("word_valid", 32'(word_valid), 32'(e.wv));
                    if (e.wv) check("bits_word", 32'(bits_word), 32'(e.word));
                    check("sync_lock", 32'(sync_lock), 32'(e.lock));
                    check("err_illegal", 32'(err_illegal), 32'(e.ei));
                    check("err_count", 32'(err_count), 32'(e.ecnt));
                    $display("event t=%0t bv=%b bo=%b wv=%b word=%h lock=%b ei=%b ecnt=%0d",
                             $time, bit_valid, bit_out, word_valid, bits_word, sync_lock,
                             err_illegal, err_count);
                end
            end
            last_lock = sync_lock;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int budget;
        logic [3:0] relock_a [3];
        logic [3:0] relock_b [3];
        reset = 1'b1;
        code_valid = 1'b0;
        code_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;

        // Acquisition: 3 -> CHECK, then three legal steps lock on code 0.
        send(4'h3); send(4'h4); send(4'h5);
        exp_lock();
        send(4'h0);

        // Word 0xB2 from prev=0, with a 5-cycle gap after four bits.
        exp_bit(1'b1, 1'b0, '0); send(4'h3);
        exp_bit(1'b0, 1'b0, '0); send(4'h4);
        exp_bit(1'b1, 1'b0, '0); send(4'h2);
        exp_bit(1'b1, 1'b0, '0); send(4'h0);
        idle(5);
        check("gap_bit_out", 32'(bit_out), 32'd1);
        check("gap_sync_lock", 32'(sync_lock), 32'd1);
        exp_bit(1'b0, 1'b0, '0); send(4'h1);
        exp_bit(1'b0, 1'b0, '0); send(4'h2);
        exp_bit(1'b1, 1'b0, '0); send(4'h0);
        exp_bit(1'b0, 1'b1, 8'hB2); send(4'h1);

        // Repeated code while locked, then relock via 2,3,4.
        exp_err(); send(4'h1);
        send(4'h2); send(4'h3);
        exp_lock(); send(4'h4);

        // Illegal code 7 drops to HUNT; code 2 enters CHECK silently; relock.
        exp_err(); send(4'h7);
        send(4'h2); send(4'h3); send(4'h4);
        exp_lock(); send(4'h5);

        // Three more violations (five total) with relocks: count saturates at 3.
        relock_a = '{4'h0, 4'h1, 4'h2};
        relock_b = '{4'h3, 4'h4, 4'h5};
        exp_err(); send(4'h5);
        send(relock_a[0]); send(relock_a[1]); exp_lock(); send(relock_a[2]);
        exp_err(); send(4'h2);
        send(relock_b[0]); send(relock_b[1]); exp_lock(); send(relock_b[2]);
        exp_err(); send(4'h5);
        send(relock_a[0]); send(relock_a[1]); exp_lock(); send(relock_a[2]);
        check("err_count_sat", 32'(err_count), 32'd3);

        // Four bits of a word (prev=2: 3,4,5,0 all bit 0), then reset with code_valid.
        exp_bit(1'b0, 1'b0, '0); send(4'h3);
        exp_bit(1'b0, 1'b0, '0); send(4'h4);
        exp_bit(1'b0, 1'b0, '0); send(4'h5);
        exp_bit(1'b0, 1'b0, '0); send(4'h0);
        exp_ecnt = '0;
        push(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        code_valid = 1'b1;
        code_in = 4'h1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        code_valid = 1'b0;
        check_all_zero("midreset");

        // Fresh lock and a full word 0x76 with no stale bits.
        send(4'h3); send(4'h4); send(4'h5);
        exp_lock(); send(4'h0);
        exp_bit(1'b0, 1'b0, '0); send(4'h1);
        exp_bit(1'b1, 1'b0, '0); send(4'h5);
        exp_bit(1'b1, 1'b0, '0); send(4'h4);
        exp_bit(1'b1, 1'b0, '0); send(4'h2);
        exp_bit(1'b0, 1'b0, '0); send(4'h3);
        exp_bit(1'b1, 1'b0, '0); send(4'h1);
        exp_bit(1'b1, 1'b0, '0); send(4'h5);
        exp_bit(1'b0, 1'b1, 8'h76); send(4'h0);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
